// File: rtl/ysyx_22040365_ctrl_pkg.sv
// Shared definitions for the ysyx_22040365 core control path:
// FSM state encoding, the ebreak word, decoder class codes and the strobe bundle.
package ysyx_22040365_ctrl_pkg;

    localparam int unsigned ITYPE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [ITYPE_W-1:0] ITYPE_INVALID = 2'b00;
    localparam logic [ITYPE_W-1:0] ITYPE_R       = 2'b01;
    localparam logic [ITYPE_W-1:0] ITYPE_I       = 2'b10;
    localparam logic [ITYPE_W-1:0] ITYPE_S       = 2'b11;

    typedef struct packed {
        logic imem_req;
        logic ren_rs1;
        logic ex_start;
        logic wen_rd;
    } ctrl_strobe_t;

    // Strobes for the state being entered; ex_start only on the first EXEC cycle.
    function automatic ctrl_strobe_t strobes_for(input ctrl_state_e nxt, input ctrl_state_e cur);
        ctrl_strobe_t s;
        s.imem_req = (nxt == ST_FETCH);
        s.ren_rs1  = (nxt == ST_DECODE);
        s.ex_start = (nxt == ST_EXEC) && (cur != ST_EXEC);
        s.wen_rd   = (nxt == ST_WB);
        return s;
    endfunction

endpackage

// File: rtl/ysyx_22040365_perfcnt.sv
// Cycle and retired-instruction counters, both wrapping modulo 2^64.
module ysyx_22040365_perfcnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_cycle,
    input  logic        inc_instret,
    output logic [63:0] cycles,
    output logic [63:0] instret
);

    logic [63:0] r_cycles;
    logic [63:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles  <= '0;
            r_instret <= '0;
        end else begin
            if (inc_cycle) begin
                r_cycles <= r_cycles + 64'd1;
            end
            if (inc_instret) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign cycles  = r_cycles;
    assign instret = r_instret;

endmodule

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle core controller: IDLE -> FETCH -> DECODE -> EXEC -> WB loop with a
// terminal HALT on ebreak, illegal instruction or fetch timeout.
module ysyx_22040365_ctrl
    import ysyx_22040365_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC      = 64'h8000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic [1:0]  inst_type,
    output logic        ren_rs1,
    output logic        ex_start,
    input  logic        ex_done,
    output logic        wen_rd,
    output logic [63:0] pc,
    output logic        halted,
    output logic        err,
    output logic [63:0] cycles,
    output logic [63:0] instret
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next;
    ctrl_strobe_t      r_strb;
    ctrl_strobe_t      w_strb;
    logic [WAIT_W-1:0] r_wait;
    logic [63:0]       r_pc;
    logic [31:0]       r_inst;
    logic              r_halted;
    logic              r_err;
    logic              w_err_set;
    logic              w_timeout;
    logic              w_inc_cycle;
    logic              w_inc_instret;

    // Next-state logic; an ack in the last allowed FETCH cycle still wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_timeout = (r_wait == WAIT_W'(FETCH_TIMEOUT - 1));
        unique case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    w_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_next    = ST_HALT;
                    w_err_set = 1'b1;
                end
            end
            ST_DECODE: begin
                if (r_inst == INST_EBREAK) begin
                    w_next = ST_HALT;
                end else if (inst_type == ITYPE_INVALID) begin
                    w_next    = ST_HALT;
                    w_err_set = 1'b1;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC:   if (ex_done) w_next = ST_WB;
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
        w_strb = strobes_for(w_next, r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_strb   <= '0;
            r_wait   <= '0;
            r_pc     <= RESET_PC;
            r_inst   <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_strb   <= w_strb;
            r_halted <= r_halted | (w_next == ST_HALT);
            r_err    <= r_err | w_err_set;
            if (r_state == ST_FETCH && imem_ack) begin
                r_inst <= imem_rdata;
            end
            if (r_state == ST_WB) begin
                r_pc <= r_pc + 64'd4;
            end
            // Held at zero outside FETCH so every FETCH entry starts a fresh wait.
            if (r_state != ST_FETCH) begin
                r_wait <= '0;
            end else if (!imem_ack) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign w_inc_cycle   = (r_state != ST_HALT);
    assign w_inc_instret = (r_state == ST_WB);

    ysyx_22040365_perfcnt u_perfcnt (
        .clk         (clk),
        .rst         (rst),
        .inc_cycle   (w_inc_cycle),
        .inc_instret (w_inc_instret),
        .cycles      (cycles),
        .instret     (instret)
    );

    assign imem_req  = r_strb.imem_req;
    assign ren_rs1   = r_strb.ren_rs1;
    assign ex_start  = r_strb.ex_start;
    assign wen_rd    = r_strb.wen_rd;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign halted    = r_halted;
    assign err       = r_err;

endmodule
